ff16_bank_arb: RTL and testbench
================================

Name: ff16_bank_arb

Overview:
Owns a bank of NREG 16-bit flip-flop registers and shares it between NREQ requesters. Each requester issues reads or writes over a valid/ready handshake. A round-robin arbiter grants at most one access per cycle, and read data returns one cycle later on a per-requester response channel. A clear sequencer zeroes the bank one register per cycle on command. The block sits between the bus-side masters and the register storage and is the only agent that drives the storage select/write strobes.

Parameters:
NREQ, 2, number of requesters (2..8)
NREG, 4, number of 16-bit registers in the bank (power of two, 2..16)
AW, 2, register address width, = log2(NREG)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester grant/accept, one-hot or zero
req_wr  in  NREQ  1 = write, 0 = read
req_addr  in  NREQ*AW  register index, requester i at bits [i*AW +: AW]
req_wdata  in  NREQ*16  write data, requester i at bits [i*16 +: 16]
rsp_valid  out  NREQ  read response valid, one cycle pulse
rsp_rdata  out  NREQ*16  read data, valid only with rsp_valid[i]; zero otherwise
clr_req  in  1  pulse: start zeroing the whole bank
clr_busy  out  1  high while the clear sequence runs
gnt_lock  in  NREQ  hold request (used only with the optional feature)

Behaviour:
- Reset (async assert, sync-safe release):
  - All registers are 0.
  - Round-robin pointer rr_ptr = 0, so requester 0 has first priority.
  - FSM is IDLE, clr_busy = 0, rsp_valid = 0, rsp_rdata = 0, req_ready = 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req = 1 at a rising edge. The clear index is loaded with 0.
  - In CLEAR, register[clr_idx] <= 0 each cycle and clr_idx increments.
  - CLEAR -> IDLE at the edge that clears register NREG-1. Clear takes exactly NREG cycles.
  - clr_req is ignored while in CLEAR (no restart).
- Arbitration (IDLE only; req_ready = 0 in CLEAR):
  - req_ready is combinational from req_valid and rr_ptr.
  - Grant goes to the first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - At most one bit of req_ready is set. req_ready[i] never asserts without req_valid[i].
  - A transfer occurs at an edge where req_valid[i] & req_ready[i]. Then rr_ptr <= (i+1) mod NREQ.
  - With no transfer, rr_ptr holds.
- Simultaneous clr_req and grant in IDLE: the granted access completes at that edge, and the FSM enters CLEAR at the same edge.
- Write: register[req_addr_i] <= req_wdata_i at the transfer edge. No response is generated.
- Read:
  - rsp_rdata[i] <= register[req_addr_i] as held before the transfer edge; rsp_valid[i] <= 1 at that edge.
  - The next edge returns rsp_valid to 0 unless another read by i transfers. Back-to-back reads give continuous rsp_valid.
  - A read granted the cycle after a write to the same address returns the new data.
- Response channel has no backpressure; requesters must sample rsp_* when valid.
- Requesters must hold valid, wr, addr and wdata stable until ready; this is a bench assertion, not a design check.
- Out-of-range addresses cannot occur because NREG = 2^AW.
- Reset mid-operation returns to the reset state immediately. In-flight responses and a partial clear are dropped; the bank reads 0 after reset.

Optional Feature:
- Macro: FF16_ARB_LOCK_EN.
- Defined:
  - If the requester granted at a transfer edge has gnt_lock[i] = 1, it becomes the locked owner.
  - rr_ptr is held at i, and only requester i can be granted until it completes a transfer with gnt_lock[i] = 0.
  - clr_req is deferred (latched pending) until the lock is released, then CLEAR starts on the next edge.
- Undefined: gnt_lock is ignored (port kept, unconnected internally) and pure round-robin applies.

Decomposition:
- Shared package ff16_pkg holds:
  - data width constant DW = 16;
  - FSM state enum {ST_IDLE, ST_CLEAR};
  - function rr_pick(valid, ptr) returning a one-hot grant.
- One sub-module is natural: ff16_rr_arb (NREQ, combinational pick plus registered rr_ptr). It is reused by other shared-resource blocks.
- The register array and FSM stay in ff16_bank_arb.

Test Plan:
- Reset then idle: after rst deasserts, read reg 2 by requester 0 -> rsp_valid[0] pulses 1 cycle later with rdata 0x0000, and rsp_valid[1] stays 0.
- Write then read:
  - Requester 1 writes 0xBEEF to reg 3 and is granted at once.
  - Next cycle requester 0 reads reg 3 -> rsp_rdata[0] = 0xBEEF, one cycle after grant.
- Contention: both requesters hold valid continuously for 6 writes each -> grants alternate 0,1,0,1,... starting with 0. No cycle grants both, and no requester waits more than 1 cycle.
- Clear:
  - Write 0x1234 to all 4 registers, then pulse clr_req -> clr_busy = 1 for exactly 4 cycles and req_ready = 0 throughout.
  - Subsequent reads return 0x0000.
- Reset mid-clear: assert rst in the 2nd cycle of CLEAR -> clr_busy, rsp_valid and rr_ptr are 0 immediately, and all reads return 0.
- Lock (FF16_ARB_LOCK_EN defined):
  - Requester 1 performs 3 transfers with gnt_lock = 1,1,0 while requester 0 holds valid.
  - Requester 0 is granted only after the third transfer.
  - A clr_req issued during the lock starts CLEAR after release.

Source files
------------

// File: rtl/ff16_pkg.sv
// Shared definitions for the ff16 register-bank arbiter family:
// data width, sequencer state encoding and the round-robin pick helper.
package ff16_pkg;

  localparam int DW     = 16;
  localparam int MAXREQ = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // One-hot grant to the first valid requester at or after ptr, wrapping at nreq.
  // Widths are fixed at the maximum requester count so callers zero-extend.
  function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] valid,
                                                input logic [2:0]        ptr,
                                                input int unsigned       nreq);
    logic [MAXREQ-1:0] gnt;
    logic              found;
    int unsigned       idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAXREQ; k++) begin
      idx = (32'(ptr) + k) % nreq;
      if (!found && (k < nreq) && valid[idx[2:0]]) begin
        gnt[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/ff16_rr_arb.sv
// Round-robin arbiter: combinational one-hot pick plus a registered
// priority pointer. hold parks the pointer on the current winner instead
// of advancing past it (used to keep a locked owner at top priority).
module ff16_rr_arb
  import ff16_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            hold,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   rr_ptr
);

  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [MAXREQ-1:0] valid_ext;
  logic [MAXREQ-1:0] pick;
  logic [2:0]        ptr_ext;
  logic [PW-1:0]     gnt_idx;
  logic              unused_pick;

  assign unused_pick = ^pick;
  assign rr_ptr      = rr_ptr_q;

  // Grant selection from the current pointer
  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid;
    ptr_ext               = '0;
    ptr_ext[PW-1:0]       = rr_ptr_q;
    pick                  = rr_pick(valid_ext, ptr_ext, NREQ);
    gnt                   = en ? pick[NREQ-1:0] : '0;
  end

  // Encode winner and compute the next pointer
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_idx = PW'(i);
    end
    rr_ptr_d = rr_ptr_q;
    if (|gnt) begin
      if (hold)                          rr_ptr_d = gnt_idx;
      else if (gnt_idx == PW'(NREQ - 1)) rr_ptr_d = '0;
      else                               rr_ptr_d = gnt_idx + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/ff16_bank_arb.sv
// Bank of NREG 16-bit registers shared by NREQ requesters through a
// round-robin arbiter, with a one-register-per-cycle clear sequencer.
// Optional build macro FF16_ARB_LOCK_EN: a granted requester with
// gnt_lock set keeps exclusive ownership until it transfers with gnt_lock
// clear; clear commands wait until ownership is released.
//
// state    | meaning
// ST_IDLE  | arbitration active, accesses accepted
// ST_CLEAR | zeroing register clr_idx each cycle, no grants
module ff16_bank_arb
  import ff16_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  input  logic               clr_req,
  output logic               clr_busy,
  input  logic [NREQ-1:0]    gnt_lock
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_idx_q, clr_idx_d;
  logic [DW-1:0]       bank_q [NREG];
  logic [DW-1:0]       bank_d [NREG];
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [NREQ*DW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                arb_en;
  logic                arb_hold;
  logic [NREQ-1:0]     arb_valid;
  logic                clr_go;
  logic [PW-1:0]       unused_rr_ptr;

  ff16_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .hold   (arb_hold),
    .valid  (arb_valid),
    .gnt    (req_ready),
    .rr_ptr (unused_rr_ptr)
  );

`ifdef FF16_ARB_LOCK_EN
  logic          lock_act_q, lock_act_d;
  logic [PW-1:0] lock_own_q, lock_own_d;
  logic          clr_pend_q, clr_pend_d;

  // Restrict arbitration to the locked owner
  always_comb begin
    arb_valid = req_valid;
    if (lock_act_q) begin
      arb_valid             = '0;
      arb_valid[lock_own_q] = req_valid[lock_own_q];
    end
  end

  // Lock ownership follows the gnt_lock of each granted transfer
  always_comb begin
    lock_act_d = lock_act_q;
    lock_own_d = lock_own_q;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        lock_act_d = gnt_lock[i];
        lock_own_d = PW'(i);
      end
    end
  end

  // Clear waits while a lock is held or being taken this cycle
  always_comb begin
    arb_hold   = |(req_ready & gnt_lock);
    clr_go     = (clr_req | clr_pend_q) & ~lock_act_q & ~lock_act_d;
    clr_pend_d = (state_q == ST_IDLE) & (clr_req | clr_pend_q) & ~clr_go;
  end

  // Lock and pending-clear registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_act_q <= 1'b0;
      lock_own_q <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
      clr_pend_q <= clr_pend_d;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^gnt_lock;
  assign arb_valid   = req_valid;
  assign arb_hold    = 1'b0;
  assign clr_go      = clr_req;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // FSM next state: clear walks every index once, then returns to idle
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_go) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(NREG - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    clr_busy = (state_q == ST_CLEAR);
    arb_en   = (state_q == ST_IDLE);
  end

  // Bank and response next values from the clear step and the granted access
  always_comb begin
    bank_d      = bank_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    if (state_q == ST_CLEAR) bank_d[clr_idx_q] = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        if (req_wr[i]) begin
          bank_d[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
        end else begin
          rsp_valid_d[i]            = 1'b1;
          rsp_rdata_d[i*DW +: DW]   = bank_q[req_addr[i*AW +: AW]];
        end
      end
    end
  end

  // Bank and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) bank_q[r] <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      bank_q      <= bank_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ff16_bank_arb.sv
// Scoreboard bench for ff16_bank_arb (NREQ=2, NREG=4).
module tb_ff16_bank_arb;

  localparam int NREQ = 2;
  localparam int NREG = 4;
  localparam int AW   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_wr = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*16-1:0] req_wdata = '0;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ*16-1:0] rsp_rdata;
  logic               clr_req = 1'b0;
  logic               clr_busy;
  logic [NREQ-1:0]    gnt_lock = '0;

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl [NREG];
  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];
  int          gnt_log [$];
  bit          log_en = 1'b0;

  ff16_bank_arb #(.NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .gnt_lock  (gnt_lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: pops expected read data whenever a response is presented
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_legal",
          32'(((req_ready & (req_ready - 2'd1)) == 0) && ((req_ready & ~req_valid) == 0)
              && !(clr_busy && (|req_ready))), 1);
      if (log_en && (|req_ready)) gnt_log.push_back(req_ready[1] ? 1 : 0);
      if (rsp_valid[0]) begin
        if (exp0.size() == 0) chk("rsp0_unexpected", 1, 0);
        else                  chk("rsp0_data", rsp_rdata[15:0], exp0.pop_front());
      end else chk("rsp0_idle_zero", rsp_rdata[15:0], 0);
      if (rsp_valid[1]) begin
        if (exp1.size() == 0) chk("rsp1_unexpected", 1, 0);
        else                  chk("rsp1_data", rsp_rdata[31:16], exp1.pop_front());
      end else chk("rsp1_idle_zero", rsp_rdata[31:16], 0);
    end
  end

  // Drive one request and hold it until accepted; records expectation at grant
  task automatic issue(input int i, input bit wr, input logic [1:0] a, input logic [15:0] d,
                       input bit lk, output int waited);
    bit ok;
    waited = 0;
    ok     = 1'b0;
    req_wr[i]            = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*16 +: 16] = d;
    gnt_lock[i]          = lk;
    req_valid[i]         = 1'b1;
    while (!ok) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1'b1;
      else begin
        waited++;
        if (waited > 60) begin
          chk("grant_timeout", 32'(i), 32'hFFFF);
          break;
        end
      end
    end
    if (ok) begin
      if (wr)          mdl[a] = d;
      else if (i == 0) exp0.push_back(mdl[a]);
      else             exp1.push_back(mdl[a]);
      @(posedge clk);
      #1;
    end
    req_valid[i] = 1'b0;
    gnt_lock[i]  = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    for (int r = 0; r < NREG; r++) mdl[r] = 16'h0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (clr_busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("clear_done_bound", 32'(clr_busy), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w0max, w1max, busy_cnt;
    for (int r = 0; r < NREG; r++) mdl[r] = 16'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rr_ptr", 32'(dut.u_arb.rr_ptr_q), 0);
    @(posedge clk);
    #1;

    // Read after reset
    issue(0, 1'b0, 2'd2, 16'h0, 1'b0, w);

    // Write then read, crossing requesters; last read parks pointer at 0
    issue(1, 1'b1, 2'd3, 16'hBEEF, 1'b0, w);
    chk("wr_immediate_wait", 32'(w), 0);
    issue(0, 1'b0, 2'd3, 16'h0, 1'b0, w);
    chk("rd_after_wr_wait", 32'(w), 0);
    issue(1, 1'b0, 2'd3, 16'h0, 1'b0, w);

    // Contention: both hold valid for six writes each
    gnt_log.delete();
    log_en = 1'b1;
    w0max = 0;
    w1max = 0;
    fork
      begin
        int wa;
        for (int k = 0; k < 6; k++) begin
          issue(0, 1'b1, 2'(k % 4), 16'hA000 + 16'(k), 1'b0, wa);
          if (wa > w0max) w0max = wa;
        end
      end
      begin
        int wb;
        for (int k = 0; k < 6; k++) begin
          issue(1, 1'b1, 2'((k + 1) % 4), 16'hB000 + 16'(k), 1'b0, wb);
          if (wb > w1max) w1max = wb;
        end
      end
    join
    log_en = 1'b0;
    chk("cont_gnt_count", 32'(gnt_log.size()), 12);
    for (int n = 0; n < gnt_log.size() && n < 12; n++) chk("cont_gnt_order", 32'(gnt_log[n]), 32'(n % 2));
    chk("cont_wait0_max1", 32'(w0max <= 1), 1);
    chk("cont_wait1_max1", 32'(w1max <= 1), 1);
    for (int r = 0; r < NREG; r++) issue(0, 1'b0, 2'(r), 16'h0, 1'b0, w);

    // Clear: fill, clear, verify duration and blocked grants
    for (int r = 0; r < NREG; r++) issue(0, 1'b1, 2'(r), 16'h1234, 1'b0, w);
    chk("pre_clear_idle", 32'(clr_busy), 0);
    pulse_clr();
    req_wr[1]            = 1'b0;
    req_addr[1*AW +: AW] = 2'd1;
    req_valid[1]         = 1'b1;
    busy_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!clr_busy) break;
      busy_cnt++;
      chk("clear_ready_low", 32'(req_ready), 0);
    end
    req_valid[1] = 1'b0;
    chk("clear_cycles", 32'(busy_cnt), 4);
    @(posedge clk);
    #1;
    for (int r = 0; r < NREG; r++) issue(1, 1'b0, 2'(r), 16'h0, 1'b0, w);

    // Reset in the second cycle of a clear
    issue(1, 1'b1, 2'd3, 16'h5555, 1'b0, w);
    issue(0, 1'b1, 2'd0, 16'hAAAA, 1'b0, w);
    chk("pre_rst_rr_ptr", 32'(dut.u_arb.rr_ptr_q), 1);
    pulse_clr();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midclr_clr_busy", 32'(clr_busy), 0);
    chk("midclr_rsp_valid", 32'(rsp_valid), 0);
    chk("midclr_rr_ptr", 32'(dut.u_arb.rr_ptr_q), 0);
    @(negedge clk);
    rst = 1'b0;
    exp0.delete();
    exp1.delete();
    for (int r = 0; r < NREG; r++) mdl[r] = 16'h0;
    @(posedge clk);
    #1;
    gnt_log.delete();
    log_en = 1'b1;
    fork
      begin int wc; issue(0, 1'b0, 2'd0, 16'h0, 1'b0, wc); end
      begin int wd; issue(1, 1'b0, 2'd3, 16'h0, 1'b0, wd); end
    join
    log_en = 1'b0;
    chk("post_rst_gnt_count", 32'(gnt_log.size()), 2);
    if (gnt_log.size() == 2) begin
      chk("post_rst_first_gnt", 32'(gnt_log[0]), 0);
      chk("post_rst_second_gnt", 32'(gnt_log[1]), 1);
    end
    issue(0, 1'b0, 2'd1, 16'h0, 1'b0, w);
    issue(0, 1'b0, 2'd2, 16'h0, 1'b0, w);

`ifdef FF16_ARB_LOCK_EN
    // Lock: requester 1 keeps ownership for three transfers, clear deferred
    gnt_log.delete();
    log_en = 1'b1;
    fork
      begin
        int we;
        issue(1, 1'b1, 2'd0, 16'h0101, 1'b1, we);
        issue(1, 1'b1, 2'd1, 16'h0202, 1'b1, we);
        issue(1, 1'b1, 2'd2, 16'h0303, 1'b0, we);
        chk("lock_clear_deferred", 32'(clr_busy), 0);
      end
      begin
        int wf;
        @(posedge clk);
        #2;
        issue(0, 1'b1, 2'd3, 16'h0404, 1'b0, wf);
      end
      begin
        @(posedge clk);
        #2;
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
      end
    join
    log_en = 1'b0;
    chk("lock_clear_started", 32'(clr_busy), 1);
    chk("lock_gnt_count", 32'(gnt_log.size()), 4);
    for (int n = 0; n < gnt_log.size() && n < 4; n++) chk("lock_gnt_order", 32'(gnt_log[n]), (n < 3) ? 1 : 0);
    for (int r = 0; r < NREG; r++) mdl[r] = 16'h0;
    wait_idle();
    issue(0, 1'b0, 2'd3, 16'h0, 1'b0, w);
    issue(1, 1'b0, 2'd0, 16'h0, 1'b0, w);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard0_empty", 32'(exp0.size()), 0);
    chk("scoreboard1_empty", 32'(exp1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
